// File: rtl/e203_fpu_rf_sched.sv
// FPU register-file scheduler: busy scoreboard for dispatch hazards
// plus a round-robin arbiter for the single regfile write port.
module e203_fpu_rf_sched #(
  parameter int RFIDX_W = 5,
  parameter int XLEN    = 32,
  parameter int NREG    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [RFIDX_W-1:0] disp_rs1_idx,
  input  logic [RFIDX_W-1:0] disp_rs2_idx,
  input  logic [RFIDX_W-1:0] disp_rs3_idx,
  input  logic               disp_rs1_en,
  input  logic               disp_rs2_en,
  input  logic               disp_rs3_en,
  input  logic [RFIDX_W-1:0] disp_rd_idx,
  input  logic               disp_rd_en,
  input  logic               wb0_valid,
  output logic               wb0_ready,
  input  logic [RFIDX_W-1:0] wb0_idx,
  input  logic [XLEN-1:0]    wb0_dat,
  input  logic               wb1_valid,
  output logic               wb1_ready,
  input  logic [RFIDX_W-1:0] wb1_idx,
  input  logic [XLEN-1:0]    wb1_dat,
  output logic               wbck_dest_wen,
  output logic [RFIDX_W-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]    wbck_dest_dat,
  output logic [NREG-1:0]    busy_vec,
  output logic               sb_err
);

  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_nxt;
  logic               rr_ptr;
  logic               set_en;
  logic               gnt_any;
  logic               contest;
  logic               err_hit;
  logic [RFIDX_W-1:0] gnt_idx;
  logic [XLEN-1:0]    gnt_dat;

  assign busy_vec = busy;

  // Source or destination still owned by an in-flight write blocks dispatch.
  assign disp_ready = ~(disp_rs1_en & busy[disp_rs1_idx])
                    & ~(disp_rs2_en & busy[disp_rs2_idx])
                    & ~(disp_rs3_en & busy[disp_rs3_idx])
                    & ~(disp_rd_en  & busy[disp_rd_idx]);

  assign set_en = disp_valid & disp_ready & disp_rd_en;

  // Uncontested requester wins; on contention rr_ptr picks the winner.
  assign contest   = wb0_valid & wb1_valid;
  assign wb0_ready = wb0_valid & (~wb1_valid | ~rr_ptr);
  assign wb1_ready = wb1_valid & (~wb0_valid |  rr_ptr);
  assign gnt_any   = wb0_ready | wb1_ready;

  // Steer the winning request onto the write port.
  always_comb begin
    gnt_idx = '0;
    gnt_dat = '0;
    unique case (1'b1)
      wb0_ready: begin
        gnt_idx = wb0_idx;
        gnt_dat = wb0_dat;
      end
      wb1_ready: begin
        gnt_idx = wb1_idx;
        gnt_dat = wb1_dat;
      end
      default: ;
    endcase
  end

  // Writing a register nobody reserved means a broken producer.
  assign err_hit = gnt_any & ~busy[gnt_idx]
                 & ~(set_en & (disp_rd_idx == gnt_idx));

  // Clear with the regfile write, then set; set wins on a tie.
  always_comb begin
    busy_nxt = busy;
    if (wbck_dest_wen)
      busy_nxt[wbck_dest_idx] = 1'b0;
    if (set_en)
      busy_nxt[disp_rd_idx] = 1'b1;
  end

  // Scoreboard, fairness pointer and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      rr_ptr <= 1'b0;
      sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (contest)
        rr_ptr <= ~rr_ptr;
      if (err_hit)
        sb_err <= 1'b1;
    end
  end

  // Registered write port; idx/dat hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbck_dest_wen <= 1'b0;
      wbck_dest_idx <= '0;
      wbck_dest_dat <= '0;
    end else begin
      wbck_dest_wen <= gnt_any;
      if (gnt_any) begin
        wbck_dest_idx <= gnt_idx;
        wbck_dest_dat <= gnt_dat;
      end
    end
  end

endmodule

// File: tb/tb_e203_fpu_rf_sched.sv
// Directed table-driven bench for the FPU regfile scheduler.
// Each row: inputs for one cycle and outputs expected in that cycle.
module tb_e203_fpu_rf_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_rs1_idx, disp_rs2_idx, disp_rs3_idx;
  logic        disp_rs1_en, disp_rs2_en, disp_rs3_en;
  logic [4:0]  disp_rd_idx;
  logic        disp_rd_en;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_idx;
  logic [31:0] wb0_dat;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_idx;
  logic [31:0] wb1_dat;
  logic        wbck_dest_wen;
  logic [4:0]  wbck_dest_idx;
  logic [31:0] wbck_dest_dat;
  logic [31:0] busy_vec;
  logic        sb_err;

  int n_cmp = 0;
  int n_bad = 0;

  e203_fpu_rf_sched dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
    .disp_rs3_idx(disp_rs3_idx),
    .disp_rs1_en(disp_rs1_en), .disp_rs2_en(disp_rs2_en),
    .disp_rs3_en(disp_rs3_en),
    .disp_rd_idx(disp_rd_idx), .disp_rd_en(disp_rd_en),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready),
    .wb0_idx(wb0_idx), .wb0_dat(wb0_dat),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready),
    .wb1_idx(wb1_idx), .wb1_dat(wb1_dat),
    .wbck_dest_wen(wbck_dest_wen), .wbck_dest_idx(wbck_dest_idx),
    .wbck_dest_dat(wbck_dest_dat),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rs;
    logic [2:0]  se;
    logic [4:0]  rd;
    logic        rde;
    logic        w0v;
    logic [4:0]  w0i;
    logic [31:0] w0d;
    logic        w1v;
    logic [4:0]  w1i;
    logic [31:0] w1d;
    logic        rdy;
    logic        g0;
    logic        g1;
    logic        wen;
    logic [4:0]  widx;
    logic [31:0] wdat;
    logic [31:0] busy;
    logic        err;
  } vec_t;

  vec_t tv[35];

  function automatic vec_t mk(
    logic dv, logic [4:0] rs, logic [2:0] se,
    logic [4:0] rd, logic rde,
    logic w0v, logic [4:0] w0i, logic [31:0] w0d,
    logic w1v, logic [4:0] w1i, logic [31:0] w1d,
    logic rdy, logic g0, logic g1, logic wen,
    logic [4:0] widx, logic [31:0] wdat,
    logic [31:0] busy, logic err);
    vec_t r;
    r.dv = dv; r.rs = rs; r.se = se; r.rd = rd; r.rde = rde;
    r.w0v = w0v; r.w0i = w0i; r.w0d = w0d;
    r.w1v = w1v; r.w1i = w1i; r.w1d = w1d;
    r.rdy = rdy; r.g0 = g0; r.g1 = g1; r.wen = wen;
    r.widx = widx; r.wdat = wdat; r.busy = busy; r.err = err;
    return r;
  endfunction

  task automatic chk(int row, string nm,
                     logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h want %h", row, nm, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    disp_valid   = r.dv;
    disp_rs1_idx = r.rs;
    disp_rs2_idx = r.rs;
    disp_rs3_idx = r.rs;
    disp_rs1_en  = r.se[0];
    disp_rs2_en  = r.se[1];
    disp_rs3_en  = r.se[2];
    disp_rd_idx  = r.rd;
    disp_rd_en   = r.rde;
    wb0_valid    = r.w0v;
    wb0_idx      = r.w0i;
    wb0_dat      = r.w0d;
    wb1_valid    = r.w1v;
    wb1_idx      = r.w1i;
    wb1_dat      = r.w1d;
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk);
      #1;
      drive(tv[i]);
      #1;
      chk(i, "disp_ready", 32'(disp_ready), 32'(tv[i].rdy));
      chk(i, "wb0_ready",  32'(wb0_ready),  32'(tv[i].g0));
      chk(i, "wb1_ready",  32'(wb1_ready),  32'(tv[i].g1));
      chk(i, "wen",        32'(wbck_dest_wen), 32'(tv[i].wen));
      chk(i, "widx",       32'(wbck_dest_idx), 32'(tv[i].widx));
      chk(i, "wdat",       wbck_dest_dat, tv[i].wdat);
      chk(i, "busy_vec",   busy_vec, tv[i].busy);
      chk(i, "sb_err",     32'(sb_err), 32'(tv[i].err));
    end
  endtask

  localparam logic [31:0] ONE = 32'h3F80_0000;

  initial begin
    // dv rs se rd rde | w0 | w1 | rdy g0 g1 wen idx dat busy err
    // RAW on f5, write-back clears it
    tv[0]  = mk(1,0,3'b000,5,1, 0,0,0, 0,0,0, 1,0,0,0,0,0,       32'h00,0);
    tv[1]  = mk(1,5,3'b001,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,       32'h20,0);
    tv[2]  = mk(0,5,3'b001,0,0, 1,5,ONE, 0,0,0, 0,1,0,0,0,0,     32'h20,0);
    tv[3]  = mk(0,5,3'b100,0,0, 0,0,0, 0,0,0, 0,0,0,1,5,ONE,     32'h20,0);
    tv[4]  = mk(0,5,3'b010,0,0, 0,0,0, 0,0,0, 1,0,0,0,5,ONE,     32'h00,0);
    // contested write-back, req0 first
    tv[5]  = mk(1,0,3'b000,1,1, 0,0,0, 0,0,0, 1,0,0,0,5,ONE,     32'h00,0);
    tv[6]  = mk(1,0,3'b000,2,1, 0,0,0, 0,0,0, 1,0,0,0,5,ONE,     32'h02,0);
    tv[7]  = mk(0,0,3'b000,0,0, 1,1,32'h11, 1,2,32'h22,
                1,1,0,0,5,ONE, 32'h06,0);
    tv[8]  = mk(0,0,3'b000,0,0, 0,0,0, 1,2,32'h22,
                1,0,1,1,1,32'h11, 32'h06,0);
    tv[9]  = mk(0,0,3'b000,0,0, 0,0,0, 0,0,0, 1,0,0,1,2,32'h22, 32'h04,0);
    // WAW on f3
    tv[10] = mk(1,0,3'b000,3,1, 0,0,0, 0,0,0, 1,0,0,0,2,32'h22, 32'h00,0);
    tv[11] = mk(1,0,3'b000,3,1, 0,0,0, 0,0,0, 0,0,0,0,2,32'h22, 32'h08,0);
    tv[12] = mk(1,0,3'b000,3,1, 1,3,32'h33, 0,0,0,
                0,1,0,0,2,32'h22, 32'h08,0);
    tv[13] = mk(1,0,3'b000,3,1, 0,0,0, 0,0,0, 0,0,0,1,3,32'h33, 32'h08,0);
    tv[14] = mk(1,0,3'b000,3,1, 0,0,0, 0,0,0, 1,0,0,0,3,32'h33, 32'h00,0);
    tv[15] = mk(0,3,3'b000,3,0, 0,0,0, 0,0,0, 1,0,0,0,3,32'h33, 32'h08,0);
    // unreserved write to f7
    tv[16] = mk(0,0,3'b000,0,0, 0,0,0, 1,7,32'h77,
                1,0,1,0,3,32'h33, 32'h08,0);
    tv[17] = mk(0,0,3'b000,0,0, 0,0,0, 0,0,0, 1,0,0,1,7,32'h77, 32'h08,1);
    // fill f0..f7 busy, then one pending write
    tv[18] = mk(1,0,3'b000,0,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h08,1);
    tv[19] = mk(1,0,3'b000,1,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h09,1);
    tv[20] = mk(1,0,3'b000,2,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h0B,1);
    tv[21] = mk(1,0,3'b000,4,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h0F,1);
    tv[22] = mk(1,0,3'b000,5,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h1F,1);
    tv[23] = mk(1,0,3'b000,6,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h3F,1);
    tv[24] = mk(1,0,3'b000,7,1, 0,0,0, 0,0,0, 1,0,0,0,7,32'h77, 32'h7F,1);
    tv[25] = mk(0,0,3'b000,0,0, 1,0,32'hAA, 0,0,0,
                1,1,0,0,7,32'h77, 32'hFF,1);
    tv[26] = mk(0,0,3'b000,0,0, 0,0,0, 0,0,0, 1,0,0,1,0,32'hAA, 32'hFF,1);
    // after reset: six contested cycles alternate 0,1,0,1,0,1
    for (int k = 0; k < 6; k++)
      tv[27+k] = mk(0,0,3'b000,0,0, 1,10,32'hA0, 1,11,32'hB0,
                    1, (k%2)==0, (k%2)==1,
                    k != 0, (k%2)==1 ? 5'd10 : 5'd11,
                    k == 0 ? 32'h0 : ((k%2)==1 ? 32'hA0 : 32'hB0),
                    32'h0, k != 0);
    tv[27].widx = 5'd0;
    tv[33] = mk(0,0,3'b000,0,0, 0,0,0, 0,0,0, 1,0,0,1,11,32'hB0, 32'h0,1);
    tv[34] = mk(0,0,3'b000,0,0, 0,0,0, 0,0,0, 1,0,0,0,11,32'hB0, 32'h0,1);

    rst_n = 1'b0;
    drive(tv[34]);
    #22;
    rst_n = 1'b1;

    run_rows(0, 26);

    // asynchronous reset while a write is pending and f0..f7 are busy
    #1;
    rst_n = 1'b0;
    #1;
    chk(100, "rst wen",  32'(wbck_dest_wen), 32'h0);
    chk(100, "rst widx", 32'(wbck_dest_idx), 32'h0);
    chk(100, "rst wdat", wbck_dest_dat, 32'h0);
    chk(100, "rst busy", busy_vec, 32'h0);
    chk(100, "rst err",  32'(sb_err), 32'h0);
    chk(100, "rst rdy",  32'(disp_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_rows(27, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
